nios_spi_rx_register_0: RTL and testbench

Avalon-MM slave that gives the Nios processor a buffered receive path for 16-bit SPI words. The SPI core pushes each received word with a single-cycle strobe; the block queues the words in a small FIFO, exposes data/status/control registers on the processor bus, and raises a level interrupt. It pairs with the 16-bit SPI transmit PIO register that drives outgoing words.

---
 rtl/spi_pkg.sv | 30 +++
 rtl/nios_spi_rx_register_0_if.sv | 12 +
 rtl/nios_spi_rx_register_0_fifo.sv | 61 ++++++
 rtl/nios_spi_rx_register_0.sv | 80 ++++++++
 tb/tb_nios_spi_rx_register_0.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Register map and bit positions shared by the SPI RX/TX PIO registers and firmware headers.
package spi_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int ST_NEMPTY    = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 8;

  localparam int CT_IRQEN = 0;
  localparam int CT_FLUSH = 1;

  localparam int RX_DATA_W = 16;

  // Count is passed 8 bits wide so one helper serves every legal DEPTH (up to 64 -> 7 bits).
  function automatic logic [31:0] pack_status(input logic nempty, input logic full,
                                              input logic ovf, input logic [7:0] count);
    logic [31:0] w;
    w = '0;
    w[ST_NEMPTY] = nempty;
    w[ST_FULL]   = full;
    w[ST_OVF]    = ovf;
    w[ST_COUNT_LSB +: 8] = count;
    return w;
  endfunction

endpackage

// File: rtl/nios_spi_rx_register_0_if.sv
// Avalon-MM slave bus bundle for the SPI RX register block.
interface nios_spi_rx_register_0_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, read_n, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, read_n, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_spi_rx_register_0_fifo.sv
// Register-based synchronous FIFO for received SPI words; flush wins over push/pop.
module spi_rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_pop;
  logic              w_push;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign w_pop  = pop & ~empty & ~flush;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_push = push & (~full | w_pop) & ~flush;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/nios_spi_rx_register_0.sv
// Avalon-MM register front end for the SPI receive FIFO: decode, overflow/irq and read mux.
module nios_spi_rx_register_0
  import spi_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  nios_spi_rx_register_0_if.slave  bus,
  input  logic [RX_DATA_W-1:0]     rx_data,
  input  logic                     rx_valid,
  output logic                     irq
);

  logic                 w_rd;
  logic                 w_wr;
  logic                 w_pop;
  logic                 w_flush;
  logic                 w_ovf_set;
  logic                 w_ovf_clr;
  logic                 w_full;
  logic                 w_empty;
  logic [CW-1:0]        w_count;
  logic [RX_DATA_W-1:0] w_head;
  logic                 w_unused;
  logic                 r_ovf;
  logic                 r_irq_en;

  assign w_rd      = bus.chipselect & ~bus.read_n;
  assign w_wr      = bus.chipselect & ~bus.write_n;
  assign w_pop     = w_rd & (bus.address == ADDR_DATA) & ~w_empty;
  assign w_flush   = w_wr & (bus.address == ADDR_CTRL) & bus.writedata[CT_FLUSH];
  assign w_ovf_set = rx_valid & w_full & ~w_pop & ~w_flush;
  assign w_ovf_clr = w_wr & (bus.address == ADDR_STATUS) & bus.writedata[ST_OVF];
  assign w_unused  = ^bus.writedata[31:3];

  spi_rx_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (RX_DATA_W),
    .CW     (CW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_valid),
    .pop   (w_pop),
    .flush (w_flush),
    .wdata (rx_data),
    .rdata (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // A fresh overflow beats a software clear in the same cycle; flush clears unconditionally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf    <= 1'b0;
      r_irq_en <= 1'b0;
    end else begin
      if (w_flush)        r_ovf <= 1'b0;
      else if (w_ovf_set) r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      if (w_wr && bus.address == ADDR_CTRL) r_irq_en <= bus.writedata[CT_IRQEN];
    end
  end

  assign irq = r_irq_en & (~w_empty | r_ovf);

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:   bus.readdata = w_empty ? 32'd0 : {16'd0, w_head};
      ADDR_STATUS: bus.readdata = pack_status(~w_empty, w_full, r_ovf, 8'(w_count));
      ADDR_CTRL:   bus.readdata = {31'd0, r_irq_en};
      default:     bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nios_spi_rx_register_0.sv
// Bench for nios_spi_rx_register_0: directed vector table, corner sequences, random traffic vs queue model.
module tb_nios_spi_rx_register_0;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        irq;

  nios_spi_rx_register_0_if bus ();

  nios_spi_rx_register_0 #(.DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mq[$];
  bit          m_ovf;
  bit          m_ien;

  typedef struct {
    string       nm;
    logic [1:0]  a;
    bit          rd;
    bit          wr;
    logic [31:0] wd;
    bit          rv;
    logic [15:0] rxd;
    logic [31:0] exp_rd;
    bit          exp_irq;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] v;
    int n;
    n = mq.size();
    v = '0;
    case (a)
      2'd0: v = (n > 0) ? {16'd0, mq[0]} : 32'd0;
      2'd1: v = (32'(n) << 8) | (32'(m_ovf) << 2) | (32'(n == D) << 1) | 32'(n > 0);
      2'd2: v = {31'd0, m_ien};
      default: v = '0;
    endcase
    return v;
  endfunction

  // One bus cycle: drive at negedge, sample 1ns later, check against the model, step model at posedge.
  task automatic cyc(input logic [1:0] a, input bit rd, input bit wr, input logic [31:0] wd,
                     input bit rv, input logic [15:0] rxd,
                     output logic [31:0] rdat, output logic irqv);
    bit pop, fl, full;
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = rd | wr;
    bus.read_n     = ~rd;
    bus.write_n    = ~wr;
    bus.writedata  = wd;
    rx_valid       = rv;
    rx_data        = rxd;
    #1;
    rdat = bus.readdata;
    irqv = irq;
    chk("model_readdata", rdat, m_read(a));
    chk("model_irq", {31'd0, irqv}, {31'd0, m_ien & ((mq.size() > 0) | m_ovf)});
    @(posedge clk);
    pop  = rd && a == 2'd0 && mq.size() > 0;
    fl   = wr && a == 2'd2 && wd[1];
    full = (mq.size() == D);
    if (fl) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (rv && full && !pop)            m_ovf = 1'b1;
      else if (wr && a == 2'd1 && wd[2]) m_ovf = 1'b0;
      if (pop) void'(mq.pop_front());
      if (rv && (!full || pop)) mq.push_back(rxd);
    end
    if (wr && a == 2'd2) m_ien = wd[0];
  endtask

  task automatic rdv(input logic [1:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] r;
    logic        i;
    cyc(a, 1'b1, 1'b0, 32'd0, 1'b0, 16'd0, r, i);
    chk(nm, r, exp);
  endtask

  task automatic push(input logic [15:0] w);
    logic [31:0] r;
    logic        i;
    cyc(2'd3, 1'b0, 1'b0, 32'd0, 1'b1, w, r, i);
  endtask

  task automatic wrv(input logic [1:0] a, input logic [31:0] wd, input bit rv, input logic [15:0] rxd);
    logic [31:0] r;
    logic        i;
    cyc(a, 1'b0, 1'b1, wd, rv, rxd, r, i);
  endtask

  vec_t        vt[$];
  logic [31:0] r;
  logic        i;

  initial begin
    reset = 1'b1;
    bus.address = 2'd3; bus.chipselect = 1'b0; bus.read_n = 1'b1; bus.write_n = 1'b1;
    bus.writedata = '0; rx_valid = 1'b0; rx_data = '0;
    mq.delete(); m_ovf = 1'b0; m_ien = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    vt.push_back('{"rst_status",   2'd1, 1, 0, 32'd0, 0, 16'h0000, 32'h0000_0000, 0});
    vt.push_back('{"rst_data",     2'd0, 1, 0, 32'd0, 0, 16'h0000, 32'h0000_0000, 0});
    vt.push_back('{"push_1234",    2'd3, 0, 0, 32'd0, 1, 16'h1234, 32'h0000_0000, 0});
    vt.push_back('{"status_cnt1",  2'd1, 1, 0, 32'd0, 1, 16'hABCD, 32'h0000_0101, 0});
    vt.push_back('{"ctrl_before",  2'd2, 0, 1, 32'd1, 0, 16'h0000, 32'h0000_0000, 0});
    vt.push_back('{"status_cnt2",  2'd1, 1, 0, 32'd0, 0, 16'h0000, 32'h0000_0201, 1});
    vt.push_back('{"data_first",   2'd0, 1, 0, 32'd0, 0, 16'h0000, 32'h0000_1234, 1});
    vt.push_back('{"data_second",  2'd0, 1, 0, 32'd0, 0, 16'h0000, 32'h0000_ABCD, 1});
    vt.push_back('{"status_empty", 2'd1, 1, 0, 32'd0, 0, 16'h0000, 32'h0000_0000, 0});
    vt.push_back('{"ctrl_readbk",  2'd2, 1, 0, 32'd0, 0, 16'h0000, 32'h0000_0001, 0});
    vt.push_back('{"reserved_rd",  2'd3, 1, 0, 32'd0, 0, 16'h0000, 32'h0000_0000, 0});
    foreach (vt[k]) begin
      cyc(vt[k].a, vt[k].rd, vt[k].wr, vt[k].wd, vt[k].rv, vt[k].rxd, r, i);
      chk({vt[k].nm, "_rdata"}, r, vt[k].exp_rd);
      chk({vt[k].nm, "_irq"}, {31'd0, i}, {31'd0, vt[k].exp_irq});
    end

    // Overflow: nine pushes into an 8-deep FIFO
    for (int k = 1; k <= 9; k++) push(16'(k));
    rdv(2'd1, 32'h0000_0807, "ovf_status");
    chk("ovf_irq", {31'd0, irq}, 32'd1);
    for (int k = 1; k <= 8; k++) rdv(2'd0, 32'(k), "ovf_drain");
    rdv(2'd1, 32'h0000_0004, "ovf_sticky");
    wrv(2'd1, 32'h4, 1'b0, 16'd0);
    rdv(2'd1, 32'h0000_0000, "ovf_cleared");

    // Full FIFO with simultaneous push and pop
    for (int k = 0; k < 8; k++) push(16'(16'h10 + k));
    cyc(2'd0, 1'b1, 1'b0, 32'd0, 1'b1, 16'h00AA, r, i);
    chk("full_pp_head", r, 32'h10);
    rdv(2'd1, 32'h0000_0803, "full_pp_status");
    for (int k = 1; k < 8; k++) rdv(2'd0, 32'(16'h10 + k), "full_pp_drain");
    rdv(2'd0, 32'h0000_00AA, "full_pp_last");
    rdv(2'd1, 32'h0000_0000, "full_pp_empty");

    // Empty FIFO with simultaneous push and read
    cyc(2'd0, 1'b1, 1'b0, 32'd0, 1'b1, 16'h5555, r, i);
    chk("empty_pp_read", r, 32'h0);
    rdv(2'd0, 32'h0000_5555, "empty_pp_next");
    rdv(2'd1, 32'h0000_0000, "empty_pp_status");

    // Flush with concurrent push, overflow pending
    for (int k = 0; k < 3; k++) push(16'(16'h21 + k));
    rdv(2'd1, 32'h0000_0301, "flush_pre3");
    for (int k = 3; k < 9; k++) push(16'(16'h21 + k));
    rdv(2'd1, 32'h0000_0807, "flush_pre_ovf");
    wrv(2'd2, 32'h3, 1'b1, 16'h0077);
    rdv(2'd1, 32'h0000_0000, "flush_status");
    rdv(2'd0, 32'h0000_0000, "flush_data");
    chk("flush_irq", {31'd0, irq}, 32'd0);

    // Asynchronous reset with words queued
    for (int k = 0; k < 4; k++) push(16'(16'h40 + k));
    @(negedge clk);
    bus.address = 2'd1; bus.chipselect = 1'b0; bus.read_n = 1'b1; bus.write_n = 1'b1;
    rx_valid = 1'b1; rx_data = 16'hBEEF;
    #2 reset = 1'b1;
    #1 chk("rst_mid_status", bus.readdata, 32'h0);
    chk("rst_mid_irq", {31'd0, irq}, 32'd0);
    bus.address = 2'd0;
    #1 chk("rst_mid_data", bus.readdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; rx_valid = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_ien = 1'b0;
    rdv(2'd1, 32'h0000_0000, "rst_after_status");
    rdv(2'd2, 32'h0000_0000, "rst_after_ctrl");

    // Random traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      logic [1:0]  a;
      logic [31:0] wd;
      int          op;
      op = $urandom_range(0, 3);
      a  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      wd = $urandom;
      if (op == 2 && a == 2'd2 && $urandom_range(0, 15) != 0) wd[1] = 1'b0;
      if (op == 2 && a == 2'd0) a = 2'd1;
      cyc(a, op == 1 || op == 3, op == 2, wd, $urandom_range(0, 2) != 0, 16'($urandom), r, i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
